// File: rtl/mips_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM state
// encoding, access timeout and word-alignment helpers.
package mips_pkg;

    // Memory access FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_e;

    // Last WAIT count before an unanswered access is abandoned
    localparam logic [7:0]  MEM_TIMEOUT     = 8'd255;

    // Clears the byte offset so only word addresses reach the memory
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Word-align a byte address
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues data-memory accesses for loads/stores,
// stalls the pipeline while an access is outstanding, abandons accesses
// that never complete (bus error) and registers the write-back bundle.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned
// accesses (flagged on misalign_W) instead of silently word-aligning them.
module mem_access_unit
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_M,
    input  logic        MemWr_M,
    input  logic        MemtoReg_M,
    input  logic        RegWr_M,
    input  logic [4:0]  RegWrDst_M,
    input  logic [31:0] result_M,
    input  logic [31:0] rt_data_M,
    input  logic [31:0] PC_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_M,
    output logic        RegWr_W,
    output logic [4:0]  RegWrDst_W,
    output logic [31:0] wb_data_W,
    output logic [31:0] PC_W,
    output logic        bus_err_W,
    output logic        misalign_W
);

    mau_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        regwr_q, regwr_d;
    logic [4:0]  dst_q, dst_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] pc_q, pc_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;

    logic        mem_op_s;
    logic        misaligned_s;
    logic        timeout_s;
    logic        req_s;
    logic        stall_s;

    // Decode the access and drive the memory request / stall (gated by reset)
    always_comb begin
        mem_op_s = valid_M & (MemWr_M | MemtoReg_M);
`ifdef MEM_ALIGN_CHECK_EN
        misaligned_s = mem_op_s & (result_M[1:0] != 2'b00);
`else
        misaligned_s = 1'b0;
`endif
        // Timeout cycle: request is dropped so the stage can retire with an error
        timeout_s = (state_q == ST_WAIT) && (cnt_q == MEM_TIMEOUT);
        req_s     = rst_n & (((state_q == ST_IDLE) & mem_op_s & ~misaligned_s)
                           | ((state_q == ST_WAIT) & ~timeout_s));
        stall_s   = req_s & ~dmem_ack;
    end

    // Next state of the FSM, WAIT counter and write-back bundle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regwr_d    = 1'b0;
        bus_err_d  = 1'b0;
        misalign_d = 1'b0;
        dst_d      = dst_q;
        wb_data_d  = wb_data_q;
        pc_d       = pc_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (req_s && !dmem_ack) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (timeout_s || dmem_ack) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (timeout_s) begin
            // Abandoned access: report a bus error, never write the register file
            bus_err_d = 1'b1;
            dst_d     = RegWrDst_M;
            pc_d      = PC_M;
        end else if (stall_s || !valid_M) begin
            // Bubble: nothing retires this cycle
            regwr_d = 1'b0;
        end else if (misaligned_s) begin
            misalign_d = 1'b1;
            dst_d      = RegWrDst_M;
            pc_d       = PC_M;
        end else if (MemWr_M) begin
            // Completed store: no register write-back
            dst_d = RegWrDst_M;
            pc_d  = PC_M;
        end else if (MemtoReg_M) begin
            regwr_d   = RegWr_M;
            wb_data_d = dmem_rdata;
            dst_d     = RegWrDst_M;
            pc_d      = PC_M;
        end else begin
            regwr_d   = RegWr_M;
            wb_data_d = result_M;
            dst_d     = RegWrDst_M;
            pc_d      = PC_M;
        end
    end

    // State, counter and write-back registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            regwr_q    <= 1'b0;
            dst_q      <= 5'd0;
            wb_data_q  <= 32'd0;
            pc_q       <= 32'd0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            regwr_q    <= regwr_d;
            dst_q      <= dst_d;
            wb_data_q  <= wb_data_d;
            pc_q       <= pc_d;
            bus_err_q  <= bus_err_d;
            misalign_q <= misalign_d;
        end
    end

    // Output drive
    always_comb begin
        dmem_req   = req_s;
        dmem_we    = MemWr_M;
        dmem_addr  = word_align(result_M);
        dmem_wdata = rt_data_M;
        stall_M    = stall_s;
        RegWr_W    = regwr_q;
        RegWrDst_W = dst_q;
        wb_data_W  = wb_data_q;
        PC_W       = pc_q;
        bus_err_W  = bus_err_q;
        misalign_W = misalign_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus
// randomized ALU/load/store traffic with random memory latency, checked
// against expectations derived from the stage's transaction rules.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_M, MemWr_M, MemtoReg_M, RegWr_M;
    logic [4:0]  RegWrDst_M;
    logic [31:0] result_M, rt_data_M, PC_M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall_M, RegWr_W, bus_err_W, misalign_W;
    logic [4:0]  RegWrDst_W;
    logic [31:0] wb_data_W, PC_W;

    int tests = 0;
    int fails = 0;

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_M    (valid_M),
        .MemWr_M    (MemWr_M),
        .MemtoReg_M (MemtoReg_M),
        .RegWr_M    (RegWr_M),
        .RegWrDst_M (RegWrDst_M),
        .result_M   (result_M),
        .rt_data_M  (rt_data_M),
        .PC_M       (PC_M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall_M    (stall_M),
        .RegWr_W    (RegWr_W),
        .RegWrDst_W (RegWrDst_W),
        .wb_data_W  (wb_data_W),
        .PC_W       (PC_W),
        .bus_err_W  (bus_err_W),
        .misalign_W (misalign_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Registered outputs all zero
    task automatic check_regs_zero(input string tag);
        check({tag, ".RegWr_W"},    {31'd0, RegWr_W},    32'd0);
        check({tag, ".RegWrDst_W"}, {27'd0, RegWrDst_W}, 32'd0);
        check({tag, ".wb_data_W"},  wb_data_W,           32'd0);
        check({tag, ".PC_W"},       PC_W,                32'd0);
        check({tag, ".bus_err_W"},  {31'd0, bus_err_W},  32'd0);
        check({tag, ".misalign_W"}, {31'd0, misalign_W}, 32'd0);
    endtask

    // One instruction through the stage. kind: 0 ALU, 1 load, 2 store.
    // lat = number of cycles the memory withholds ack. Called just after a posedge.
    task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input logic regwr, input logic [4:0] dst,
                       input logic [31:0] pc, input logic [31:0] rdata);
        bit is_mem, mis, exp_regwr;
        int stalls;
        is_mem = (kind != 0);
        mis    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis    = is_mem && (addr[1:0] != 2'b00);
`endif
        stalls = (is_mem && !mis) ? lat : 0;
        valid_M    = 1'b1;
        MemWr_M    = (kind == 2);
        MemtoReg_M = (kind == 1);
        RegWr_M    = regwr;
        RegWrDst_M = dst;
        result_M   = addr;
        rt_data_M  = data;
        PC_M       = pc;
        for (int c = 0; c <= stalls; c++) begin
            if (is_mem && !mis) begin
                dmem_ack   = (c == stalls);
                dmem_rdata = (c == stalls) ? rdata : $urandom;
            end else begin
                // No request: any ack must be ignored
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            check("stall_M", {31'd0, stall_M}, {31'd0, (c != stalls)});
            check("dmem_req", {31'd0, dmem_req}, {31'd0, (is_mem && !mis)});
            if (is_mem && !mis) begin
                check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                check("dmem_we", {31'd0, dmem_we}, {31'd0, (kind == 2)});
                if (kind == 2) check("dmem_wdata", dmem_wdata, data);
            end
            @(posedge clk);
            #1;
            if (c != stalls) check("bubble.RegWr_W", {31'd0, RegWr_W}, 32'd0);
        end
        exp_regwr = (kind == 2 || mis) ? 1'b0 : regwr;
        check("RegWr_W", {31'd0, RegWr_W}, {31'd0, exp_regwr});
        check("RegWrDst_W", {27'd0, RegWrDst_W}, {27'd0, dst});
        check("PC_W", PC_W, pc);
        if (kind == 0) check("wb_data_W.alu", wb_data_W, addr);
        if (kind == 1 && !mis) check("wb_data_W.load", wb_data_W, rdata);
        check("bus_err_W", {31'd0, bus_err_W}, 32'd0);
        check("misalign_W", {31'd0, misalign_W}, {31'd0, mis});
        dmem_ack = 1'b0;
    endtask

    // Idle cycle with no instruction
    task automatic bubble();
        valid_M  = 1'b0;
        dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("idle.dmem_req", {31'd0, dmem_req}, 32'd0);
        check("idle.stall_M",  {31'd0, stall_M},  32'd0);
        @(posedge clk);
        #1;
        check("idle.RegWr_W",    {31'd0, RegWr_W},    32'd0);
        check("idle.bus_err_W",  {31'd0, bus_err_W},  32'd0);
        check("idle.misalign_W", {31'd0, misalign_W}, 32'd0);
        dmem_ack = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        // Reset with a valid load presented: no request may escape
        rst_n = 1'b0;
        valid_M = 1'b1; MemWr_M = 1'b0; MemtoReg_M = 1'b1; RegWr_M = 1'b1;
        RegWrDst_M = 5'd3; result_M = 32'h0000_0100; rt_data_M = 32'd0; PC_M = 32'h40;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        #2;
        check("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst.stall_M",  {31'd0, stall_M},  32'd0);
        check_regs_zero("rst");
        @(posedge clk);
        valid_M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op, 1-cycle latency
        txn(0, 32'h0000_1234, 32'd0, 0, 1'b1, 5'd5, 32'h0000_0400, 32'd0);
        // Load with 3 wait cycles
        txn(1, 32'h0000_0100, 32'd0, 3, 1'b1, 5'd7, 32'h0000_0404, 32'hDEAD_BEEF);
        // Store with zero-wait ack
        txn(2, 32'h0000_0200, 32'hA5A5_A5A5, 0, 1'b1, 5'd9, 32'h0000_0408, 32'd0);
        bubble();
        // Load to unaligned 0x102: rejected, or word-aligned to 0x100
        txn(1, 32'h0000_0102, 32'd0, 1, 1'b1, 5'd4, 32'h0000_040C, 32'h1111_2222);
        bubble();

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            txn(int'($urandom_range(0, 2)), a, $urandom, int'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            if ($urandom_range(0, 4) == 0) bubble();
        end

        // Load that is never acknowledged: one request cycle plus 255 WAIT
        // cycles of stall, then the timeout cycle retires it with a bus error
        valid_M = 1'b1; MemWr_M = 1'b0; MemtoReg_M = 1'b1; RegWr_M = 1'b1;
        RegWrDst_M = 5'd6; result_M = 32'h0000_0300; PC_M = 32'h0000_0500;
        dmem_ack = 1'b0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!stall_M) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("timeout.stall_cycles", n, 32'd256);
        check("timeout.dmem_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("timeout.bus_err_W", {31'd0, bus_err_W}, 32'd1);
        check("timeout.RegWr_W",   {31'd0, RegWr_W},   32'd0);
        valid_M = 1'b0;
        @(posedge clk);
        #1;
        check("timeout.bus_err_pulse", {31'd0, bus_err_W}, 32'd0);

        // Leave non-zero write-back state, then reset during WAIT cycle 2
        txn(0, 32'hCAFE_0001, 32'd0, 0, 1'b1, 5'd12, 32'h0000_0600, 32'd0);
        valid_M = 1'b1; MemWr_M = 1'b0; MemtoReg_M = 1'b1; RegWr_M = 1'b1;
        RegWrDst_M = 5'd13; result_M = 32'h0000_0700; PC_M = 32'h0000_0604;
        dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("wrst.dmem_req", {31'd0, dmem_req}, 32'd0);
        check("wrst.stall_M",  {31'd0, stall_M},  32'd0);
        check_regs_zero("wrst");
        valid_M = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("wrst.idle_req", {31'd0, dmem_req}, 32'd0);
        @(posedge clk);
        #1;
        check("wrst.no_wb", {31'd0, RegWr_W}, 32'd0);
        txn(1, 32'h0000_0800, 32'd0, 2, 1'b1, 5'd14, 32'h0000_0608, 32'h5A5A_0F0F);
        bubble();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
